// File: rtl/gray_bin_arb_if.sv
// Bus between the four Gray-coded requesters and the shared converter.
// The master side drives requests and operands; the slave side returns grants and results.
interface gray_bin_arb_if #(
    parameter int W = 3
);
    logic [3:0]     req;
    logic [4*W-1:0] g_in;
    logic [3:0]     gnt;
    logic [W-1:0]   b_out;
    logic           b_valid;
    logic [1:0]     b_id;
    logic           busy;

    modport master (
        output req, g_in,
        input  gnt, b_out, b_valid, b_id, busy
    );

    modport slave (
        input  req, g_in,
        output gnt, b_out, b_valid, b_id, busy
    );
endinterface

// File: rtl/gray_bin_arb.sv
// One registered Gray-to-binary converter shared round-robin by four requesters.
// Each grant costs two cycles: an arbitration/GRANT cycle, then an OUT cycle carrying the result.
module gray_bin_arb #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    gray_bin_arb_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        OUT
    } state_t;

    state_t       state;
    state_t       next_state;
    logic [1:0]   rr_ptr;
    logic [W-1:0] g_reg;
    logic [1:0]   id_reg;
    logic [3:0]   gnt_q;
    logic [W-1:0] b_out_q;
    logic         b_valid_q;
    logic [1:0]   b_id_q;
    logic         busy_q;

    logic [1:0]   winner;
    logic         found;
    logic         arb_en;
    logic         conv_en;

    function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int k = W - 2; k >= 0; k--) begin
            b[k] = b[k+1] ^ g[k];
        end
        return b;
    endfunction

    // Scan from rr_ptr upward, wrapping at 4; the 2-bit sum provides the modulo.
    always_comb begin
        winner = rr_ptr;
        found  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!found && bus.req[rr_ptr + 2'(k)]) begin
                winner = rr_ptr + 2'(k);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        arb_en     = 1'b0;
        conv_en    = 1'b0;
        case (state)
            IDLE: begin
                if (|bus.req) begin
                    arb_en     = 1'b1;
                    next_state = GRANT;
                end
            end
            GRANT: begin
                conv_en    = 1'b1;
                next_state = OUT;
            end
            OUT: begin
                if (|bus.req) begin
                    arb_en     = 1'b1;
                    next_state = GRANT;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // busy is registered from next_state so it never glitches on state decoding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy_q <= 1'b0;
        end else begin
            state  <= next_state;
            busy_q <= (next_state != IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= 2'd0;
            g_reg     <= '0;
            id_reg    <= 2'd0;
            gnt_q     <= 4'b0000;
            b_out_q   <= '0;
            b_valid_q <= 1'b0;
            b_id_q    <= 2'd0;
        end else begin
            gnt_q     <= 4'b0000;
            b_valid_q <= conv_en;
            if (arb_en) begin
                g_reg  <= bus.g_in[int'(winner)*W +: W];
                id_reg <= winner;
                gnt_q  <= 4'b0001 << winner;
                rr_ptr <= winner + 2'd1;
            end
            if (conv_en) begin
                b_out_q <= gray2bin(g_reg);
                b_id_q  <= id_reg;
            end
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.b_out   = b_out_q;
    assign bus.b_valid = b_valid_q;
    assign bus.b_id    = b_id_q;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_gray_bin_arb.sv
// Directed bench for gray_bin_arb: expected {id, value} results are queued as requests
// are driven and popped by a monitor whenever b_valid strobes.
module tb_gray_bin_arb;
    localparam int W = 3;

    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;
    logic [W+1:0] sb[$];

    gray_bin_arb_if #(.W(W)) bus ();

    gray_bin_arb #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r);
        bus.req = r;
    endtask

    task automatic setSlice(input int i, input logic [W-1:0] v);
        bus.g_in[i*W +: W] = v;
    endtask

    task automatic pushExpect(input logic [1:0] id, input logic [W-1:0] v);
        sb.push_back({id, v});
    endtask

    // Any strobe must match the oldest outstanding expectation; a strobe with nothing queued is an error.
    always @(negedge clk) begin
        if (bus.b_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_valid", 32'(bus.b_valid), 32'd0);
            end else begin
                logic [W+1:0] e;
                e = sb.pop_front();
                checkOutput("sb_b_out", 32'(bus.b_out), 32'(e[W-1:0]));
                checkOutput("sb_b_id", 32'(bus.b_id), 32'(e[W+1:W]));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        applyStimulus(4'b0000);
        bus.g_in   = '0;

        @(negedge clk);
        checkOutput("rst_gnt", 32'(bus.gnt), 32'd0);
        checkOutput("rst_b_valid", 32'(bus.b_valid), 32'd0);
        checkOutput("rst_b_out", 32'(bus.b_out), 32'd0);
        checkOutput("rst_b_id", 32'(bus.b_id), 32'd0);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("idle_gnt", 32'(bus.gnt), 32'd0);
        checkOutput("idle_busy", 32'(bus.busy), 32'd0);
        checkOutput("idle_b_valid", 32'(bus.b_valid), 32'd0);

        // All four at once: grants 0,1,2,3, each requester drops during its own grant.
        setSlice(0, 3'b111);
        setSlice(1, 3'b010);
        setSlice(2, 3'b001);
        setSlice(3, 3'b100);
        applyStimulus(4'b1111);
        pushExpect(2'd0, 3'b101);
        pushExpect(2'd1, 3'b011);
        pushExpect(2'd2, 3'b001);
        pushExpect(2'd3, 3'b111);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("all4_gnt", 32'(bus.gnt), 32'(4'b0001 << i));
            checkOutput("all4_no_valid_in_grant", 32'(bus.b_valid), 32'd0);
            applyStimulus(bus.req & ~(4'b0001 << i));
            @(negedge clk);
            checkOutput("all4_gnt_clear", 32'(bus.gnt), 32'd0);
            checkOutput("all4_valid", 32'(bus.b_valid), 32'd1);
        end
        @(negedge clk);
        checkOutput("all4_idle_busy", 32'(bus.busy), 32'd0);
        checkOutput("all4_idle_valid", 32'(bus.b_valid), 32'd0);

        // Single request from requester 0.
        setSlice(0, 3'b110);
        applyStimulus(4'b0001);
        pushExpect(2'd0, 3'b100);
        @(negedge clk);
        checkOutput("single_gnt", 32'(bus.gnt), 32'b0001);
        checkOutput("single_busy", 32'(bus.busy), 32'd1);
        applyStimulus(4'b0000);
        @(negedge clk);
        checkOutput("single_gnt_clear", 32'(bus.gnt), 32'd0);
        checkOutput("single_busy_out", 32'(bus.busy), 32'd1);
        @(negedge clk);
        checkOutput("single_idle_busy", 32'(bus.busy), 32'd0);
        checkOutput("single_idle_valid", 32'(bus.b_valid), 32'd0);

        // Fairness: grant 2, then 0101 goes to 0 first, then 2.
        setSlice(2, 3'b011);
        applyStimulus(4'b0100);
        pushExpect(2'd2, 3'b010);
        @(negedge clk);
        checkOutput("fair_pre_gnt2", 32'(bus.gnt), 32'b0100);
        applyStimulus(4'b0000);
        repeat (2) @(negedge clk);
        setSlice(0, 3'b101);
        setSlice(2, 3'b111);
        applyStimulus(4'b0101);
        pushExpect(2'd0, 3'b110);
        pushExpect(2'd2, 3'b101);
        @(negedge clk);
        checkOutput("fair_gnt0", 32'(bus.gnt), 32'b0001);
        applyStimulus(4'b0000);
        @(negedge clk);
        applyStimulus(4'b0101);
        @(negedge clk);
        checkOutput("fair_gnt2", 32'(bus.gnt), 32'b0100);
        applyStimulus(4'b0000);
        repeat (2) @(negedge clk);
        checkOutput("fair_idle_busy", 32'(bus.busy), 32'd0);

        // Operand and req change during GRANT must not affect the delivered result.
        setSlice(1, 3'b011);
        applyStimulus(4'b0010);
        pushExpect(2'd1, 3'b010);
        @(negedge clk);
        checkOutput("stable_gnt", 32'(bus.gnt), 32'b0010);
        setSlice(1, 3'b110);
        applyStimulus(4'b0000);
        repeat (2) @(negedge clk);

        // Asynchronous reset in GRANT: outputs clear without a clock, no result follows.
        setSlice(0, 3'b111);
        applyStimulus(4'b0001);
        @(negedge clk);
        checkOutput("areset_pre_gnt", 32'(bus.gnt), 32'b0001);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("areset_gnt", 32'(bus.gnt), 32'd0);
        checkOutput("areset_busy", 32'(bus.busy), 32'd0);
        checkOutput("areset_valid", 32'(bus.b_valid), 32'd0);
        applyStimulus(4'b0000);
        @(negedge clk);
        checkOutput("areset_no_valid", 32'(bus.b_valid), 32'd0);
        rst_n = 1'b1;
        setSlice(3, 3'b010);
        applyStimulus(4'b1000);
        pushExpect(2'd3, 3'b011);
        @(negedge clk);
        checkOutput("post_reset_gnt", 32'(bus.gnt), 32'b1000);
        applyStimulus(4'b0000);
        repeat (3) @(negedge clk);
        checkOutput("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/gray_bin_arb.md
Name: gray_bin_arb

Overview:
- Shares one registered W-bit Gray-to-binary converter among four requesters.
- Uses round-robin arbitration with a req/gnt handshake.
- Returns the converted value tagged with the winner's ID and a one-cycle valid strobe.
- Sits between Gray-coded sources (encoders, async-FIFO pointers) and binary-consuming logic.

Parameters:
- W, 3, width of each Gray input and of the binary result; must be ≥ 2.

Ports:
- clk  in  1  single system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  4  request per requester, one bit each (bit i = requester i).
- g_in  in  4*W  Gray operands; requester i owns bits [i*W+W-1 : i*W]; must be stable while req[i] is high.
- gnt  out  4  one-hot grant, high for exactly one cycle.
- b_out  out  W  binary result.
- b_valid  out  1  one-cycle strobe: b_out and b_id are valid.
- b_id  out  2  index of the requester that owns b_out.
- busy  out  1  high whenever state ≠ IDLE.

Behaviour:
- Reset (rst_n low, asynchronous, wins over everything): state=IDLE, gnt=0, b_out=0, b_valid=0, b_id=0, busy=0, rr_ptr=0, g_reg=0. Any in-flight result is discarded.
- States: IDLE, GRANT, OUT.
- IDLE: if req≠0 at the edge, arbitrate → GRANT. Otherwise stay.
- GRANT: go to OUT unconditionally. req is ignored.
- OUT: if req≠0 at the edge, arbitrate → GRANT. Otherwise → IDLE.
- Arbitration edge:
  - Winner = first i with req[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo 4.
  - Latch g_reg ← g_in slice of the winner; id_reg ← winner.
  - gnt ← one-hot(winner), registered, so it is high during the GRANT cycle.
  - rr_ptr ← (winner+1) mod 4.
- GRANT→OUT edge:
  - b_out[W-1] = g_reg[W-1].
  - b_out[k] = b_out[k+1] XOR g_reg[k], for k = W-2 down to 0.
  - b_valid ← 1; b_id ← id_reg; gnt ← 0.
- Leaving OUT: b_valid ← 0. b_out and b_id hold their last value until the next OUT.
- Latency: req sampled at edge e0 → gnt high in cycle e0..e1 → b_valid high in cycle e1..e2.
- Throughput: one conversion per 2 cycles under continuous demand.
- Handshake rules:
  - A requester drops req[i] by the edge ending its gnt cycle.
  - req is not sampled in GRANT, so a requester whose req is still high during GRANT is not re-granted.
  - If req[i] is still high in OUT, that is a new request. It is arbitrated normally; round-robin gives other active requesters priority first.
- req[i] dropped during GRANT/OUT: the latched operand is still converted and delivered. There is no cancel.
- g_in changing after the arbitration edge has no effect on the in-flight result.
- Simultaneous requests: round-robin order only. No starvation; the worst-case wait is 3 grants.
- gnt, b_valid and busy are glitch-free registered outputs.
- Reset asserted mid-GRANT/OUT: outputs clear immediately. After release, the first arbitration starts at requester 0.

Test Plan:
- Reset: rst_n low → gnt=0000, b_valid=0, b_out=000, busy=0. Release with req=0 → all stay 0.
- Single request: W=3, req=0001, g_in[2:0]=110 → gnt=0001 one cycle later, then b_valid=1, b_out=100, b_id=0.
- All four simultaneous: g_in slices = 111, 010, 001, 100 (req0..3), each dropped after its gnt → grants in order 0,1,2,3 → b_out 101, 011, 001, 111 on four b_valid strobes spaced 2 cycles apart.
- Fairness: after a grant to 2, req=0101 → grant 0 before 2. Then req=0101 again → grant 2.
- Operand stability: change g_in slice and drop req during GRANT → b_out reflects the value latched at the arbitration edge.
- Async reset in GRANT: assert rst_n low mid-cycle → gnt drops without a clock, no b_valid follows. After release with req=1000 → gnt=1000.
